skid_register_slice: RTL

- Two-entry valid/ready pipeline stage that registers both the forward path and the backward path.
- Forward path: data_out and data_out_valid.
- Backward path: data_in_ready. It is driven straight from a flop, so downstream ready never reaches upstream combinationally.
- Sits between streaming datapath stages (e.g. between matmul tiles and accumulators) wherever ready fan-in limits timing.
- Sustains 1 transfer/cycle.

---
 rtl/skid_register_slice.sv | 131 +++++++++++++
 1 files changed

// File: rtl/skid_register_slice.sv
// skid_register_slice: a two-entry valid/ready register slice.
// The forward path (data_out, data_out_valid) and the backward path
// (data_in_ready) both come straight from flops, so downstream ready never
// reaches upstream combinationally. The slice sustains one transfer per cycle.
// The second entry (the skid register) catches the beat that upstream
// launches in the same cycle that the output stalls.
module skid_register_slice #(
    parameter int                    DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [1:0]            occupancy
);

    // The encoding doubles as the occupancy count: EMPTY=0, BUSY=1, FULL=2.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] out_reg_q;
    logic [DATA_WIDTH-1:0] out_reg_d;
    logic [DATA_WIDTH-1:0] skid_reg_q;
    logic [DATA_WIDTH-1:0] skid_reg_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  in_ready_q;
    logic                  in_ready_d;
    logic [1:0]            occupancy_q;
    logic [1:0]            occupancy_d;

    logic                  in_fire_s;
    logic                  out_fire_s;

    // The handshakes are qualified only by registered valid and ready.
    always_comb begin
        in_fire_s  = data_in_valid & in_ready_q;
        out_fire_s = out_valid_q & data_out_ready;
    end

    // Next-state and datapath steering. The oldest beat always sits in out_reg.
    always_comb begin
        state_d    = state_q;
        out_reg_d  = out_reg_q;
        skid_reg_d = skid_reg_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire_s) begin
                    out_reg_d = data_in;
                    state_d   = ST_BUSY;
                end else begin
                    state_d = ST_EMPTY;
                end
            end
            ST_BUSY: begin
                if (in_fire_s && out_fire_s) begin
                    out_reg_d = data_in;
                    state_d   = ST_BUSY;
                end else if (in_fire_s) begin
                    // Output is stalled, so park the new beat behind it.
                    skid_reg_d = data_in;
                    state_d    = ST_FULL;
                end else if (out_fire_s) begin
                    // out_reg keeps its last value once the slice drains.
                    state_d = ST_EMPTY;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_FULL: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire_s) begin
                    out_reg_d = skid_reg_q;
                    state_d   = ST_BUSY;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Registered outputs are decoded from next state, so they carry no
    // combinational path from the ports.
    always_comb begin
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
        occupancy_d = state_d;
    end

    // State and output flops. rst drops every held beat; skid_reg is not
    // cleared because it is never visible until it has been reloaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            out_reg_q   <= RESET_VALUE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            occupancy_q <= 2'd0;
        end else begin
            state_q     <= state_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            occupancy_q <= occupancy_d;
        end
    end

    // The skid entry loads only from the BUSY -> FULL transition.
    always_ff @(posedge clk) begin
        skid_reg_q <= skid_reg_d;
    end

    assign data_in_ready  = in_ready_q;
    assign data_out       = out_reg_q;
    assign data_out_valid = out_valid_q;
    assign occupancy      = occupancy_q;

endmodule
